// File: rtl/prog_loader_if.sv
// Program-load bus bundle: byte stream from the UART receiver plus the
// program RAM write port.
//   RX_DATA    received byte, valid while RX_VALID=1
//   RX_VALID   one-cycle strobe, one byte per strobe
//   PROG_WE    program RAM write enable, one-cycle pulse per word
//   PROG_WADDR program RAM write address
//   PROG_WDATA program RAM write data (18-bit instruction word)
// master: the loader (consumes bytes, drives the RAM write port)
// slave : the environment (supplies bytes, observes RAM writes)
interface prog_loader_if #(
   parameter int ADDR_W = 10
);
   logic [7:0]        RX_DATA;
   logic              RX_VALID;
   logic              PROG_WE;
   logic [ADDR_W-1:0] PROG_WADDR;
   logic [17:0]       PROG_WDATA;

   modport master (
      input  RX_DATA, RX_VALID,
      output PROG_WE, PROG_WADDR, PROG_WDATA
   );

   modport slave (
      output RX_DATA, RX_VALID,
      input  PROG_WE, PROG_WADDR, PROG_WDATA
   );
endinterface

// File: rtl/prog_loader.sv
// Program image loader: assembles framed UART bytes into 18-bit words,
// writes them sequentially into program RAM and holds the MCU in reset
// for the duration of the load.
//   CLK       system clock, posedge
//   RST_N     synchronous active-low reset
//   bus       prog_loader_if.master (RX byte stream in, RAM write port out)
//   MCU_HOLD  1 = hold MCU in reset
//   LOAD_DONE sticky: last frame loaded with matching checksum
//   LOAD_ERR  sticky: last frame failed (bad count, checksum or timeout)
//
// state  | meaning
// IDLE   | no frame seen since reset, waiting for START_BYTE
// CNT_HI | waiting for word count high byte
// CNT_LO | waiting for word count low byte, count is validated here
// B2     | waiting for word bits [17:16] (byte bits [1:0])
// B1     | waiting for word bits [15:8]
// B0     | waiting for word bits [7:0], word is written next cycle
// CHK    | waiting for checksum byte
// DONE   | frame loaded, MCU released, waiting for START_BYTE
// ERR    | frame failed, MCU held, waiting for START_BYTE
module prog_loader #(
   parameter int         ADDR_W         = 10,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0] START_BYTE     = 8'hA5
) (
   input  logic          CLK,
   input  logic          RST_N,
   prog_loader_if.master bus,
   output logic          MCU_HOLD,
   output logic          LOAD_DONE,
   output logic          LOAD_ERR
);

   localparam int          TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int          WCNT_W    = ADDR_W + 1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [15:0] MAX_COUNT = 16'(32'd1 << ADDR_W);

   typedef enum logic [3:0] {
      IDLE, CNT_HI, CNT_LO, B2, B1, B0, CHK, DONE, ERR
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         count_q, count_d;
   logic [1:0]          b2_q, b2_d;
   logic [7:0]          b1_q, b1_d;
   logic [7:0]          chk_q, chk_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [17:0]         wdata_q, wdata_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [15:0]         cnt_full;
   logic                in_frame;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         count_q <= '0;
         b2_q    <= '0;
         b1_q    <= '0;
         chk_q   <= '0;
         wcnt_q  <= '0;
         tmo_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         b2_q    <= b2_d;
         b1_q    <= b1_d;
         chk_q   <= chk_d;
         wcnt_q  <= wcnt_d;
         tmo_q   <= tmo_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      b2_d     = b2_q;
      b1_d     = b1_q;
      chk_d    = chk_q;
      wcnt_d   = wcnt_q;
      tmo_d    = tmo_q;
      we_d     = 1'b0;
      // address advances in the cycle after each write pulse
      waddr_d  = we_q ? waddr_q + ADDR_W'(1) : waddr_q;
      wdata_d  = wdata_q;
      hold_d   = hold_q;
      done_d   = done_q;
      err_d    = err_q;
      cnt_full = {count_q[15:8], bus.RX_DATA};
      in_frame = state_q inside {CNT_HI, CNT_LO, B2, B1, B0, CHK};

      if (bus.RX_VALID) begin
         case (state_q)
            IDLE, DONE, ERR: begin
               if (bus.RX_DATA == START_BYTE) begin
                  state_d = CNT_HI;
                  hold_d  = 1'b1;
                  done_d  = 1'b0;
                  err_d   = 1'b0;
                  waddr_d = '0;
                  chk_d   = '0;
                  wcnt_d  = '0;
                  tmo_d   = TMO_LOAD;
               end
            end
            CNT_HI: begin
               count_d[15:8] = bus.RX_DATA;
               state_d       = CNT_LO;
            end
            CNT_LO: begin
               count_d = cnt_full;
               if (cnt_full == 16'd0 || cnt_full > MAX_COUNT) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = B2;
               end
            end
            B2: begin
               b2_d    = bus.RX_DATA[1:0];
               chk_d   = chk_q + bus.RX_DATA;
               state_d = B1;
            end
            B1: begin
               b1_d    = bus.RX_DATA;
               chk_d   = chk_q + bus.RX_DATA;
               state_d = B0;
            end
            B0: begin
               chk_d   = chk_q + bus.RX_DATA;
               wdata_d = {b2_q, b1_q, bus.RX_DATA};
               we_d    = 1'b1;
               wcnt_d  = wcnt_q + WCNT_W'(1);
               state_d = (16'(wcnt_q) + 16'd1 == count_q) ? CHK : B2;
            end
            CHK: begin
               if (bus.RX_DATA == chk_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // inter-byte timer: reloaded on every byte, expires after
      // TIMEOUT_CYCLES silent cycles
      if (in_frame) begin
         if (bus.RX_VALID) begin
            tmo_d = TMO_LOAD;
         end else if (tmo_q == TMO_W'(1)) begin
            state_d = ERR;
            err_d   = 1'b1;
         end else begin
            tmo_d = tmo_q - TMO_W'(1);
         end
      end
      if (state_d inside {IDLE, DONE, ERR}) tmo_d = '0;
   end

   assign bus.PROG_WE    = we_q;
   assign bus.PROG_WADDR = waddr_q;
   assign bus.PROG_WDATA = wdata_q;
   assign MCU_HOLD       = hold_q;
   assign LOAD_DONE      = done_q;
   assign LOAD_ERR       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

   localparam int AW  = 10;
   localparam int TMO = 100;

   logic CLK = 1'b0;
   logic RST_N;
   logic MCU_HOLD, LOAD_DONE, LOAD_ERR;

   prog_loader_if #(.ADDR_W(AW)) bus ();

   prog_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO), .START_BYTE(8'hA5)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .bus       (bus),
      .MCU_HOLD  (MCU_HOLD),
      .LOAD_DONE (LOAD_DONE),
      .LOAD_ERR  (LOAD_ERR)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [17:0]   d;
   } wr_t;
   wr_t wq[$];

   // capture every RAM write pulse, sampled away from the active edge
   always @(negedge CLK) begin
      if (bus.PROG_WE === 1'b1) wq.push_back('{bus.PROG_WADDR, bus.PROG_WDATA});
   end

   typedef struct {
      logic [7:0]    b [0:11];
      int            n;
      logic          done;
      logic          err;
      logic          hold;
      int            nwe;
      logic [AW-1:0] last_a;
      logic [17:0]   last_d;
   } vec_t;
   vec_t vt [0:7];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send(input logic [7:0] bq[$], input int maxgap);
      foreach (bq[i]) begin
         @(negedge CLK);
         bus.RX_DATA  = bq[i];
         bus.RX_VALID = 1'b1;
         repeat ($urandom_range(maxgap, 0)) begin
            @(negedge CLK);
            bus.RX_VALID = 1'b0;
         end
      end
      @(negedge CLK);
      bus.RX_VALID = 1'b0;
   endtask

   task automatic check_flags(input string nm, input logic d, input logic e, input logic h);
      check({nm, "_done"}, 32'(LOAD_DONE), 32'(d));
      check({nm, "_err"},  32'(LOAD_ERR),  32'(e));
      check({nm, "_hold"}, 32'(MCU_HOLD),  32'(h));
   endtask

   logic [7:0] bq[$];
   wr_t        exp_wq[$];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{b:'{8'hA5,8'h00,8'h02,8'h01,8'h23,8'h45,8'h02,8'hAB,8'hCD,8'hE3,8'h00,8'h00},
                n:10, done:1'b1, err:1'b0, hold:1'b0, nwe:2, last_a:10'd1, last_d:18'h2ABCD};
      vt[1] = '{b:'{8'hA5,8'h00,8'h02,8'h01,8'h23,8'h45,8'h02,8'hAB,8'hCD,8'hE4,8'h00,8'h00},
                n:10, done:1'b0, err:1'b1, hold:1'b1, nwe:2, last_a:10'd1, last_d:18'h2ABCD};
      vt[2] = vt[0];
      vt[3] = '{b:'{8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                n:3, done:1'b0, err:1'b1, hold:1'b1, nwe:0, last_a:10'd0, last_d:18'h0};
      vt[4] = '{b:'{8'hA5,8'h04,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                n:3, done:1'b0, err:1'b1, hold:1'b1, nwe:0, last_a:10'd0, last_d:18'h0};
      vt[5] = '{b:'{8'h12,8'h34,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                n:2, done:1'b0, err:1'b1, hold:1'b1, nwe:0, last_a:10'd0, last_d:18'h0};
      // START_BYTE as data; upper bits of B2 ignored in word but counted in checksum
      vt[6] = '{b:'{8'hA5,8'h00,8'h01,8'hA5,8'hA5,8'hA5,8'hEF,8'h00,8'h00,8'h00,8'h00,8'h00},
                n:7, done:1'b1, err:1'b0, hold:1'b0, nwe:1, last_a:10'd0, last_d:18'h1A5A5};
      // checksum wraps past 255
      vt[7] = '{b:'{8'hA5,8'h00,8'h01,8'hFF,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                n:7, done:1'b1, err:1'b0, hold:1'b0, nwe:1, last_a:10'd0, last_d:18'h30001};

      RST_N        = 1'b0;
      bus.RX_DATA  = 8'h00;
      bus.RX_VALID = 1'b0;
      idle(3);
      check("rst_we",    32'(bus.PROG_WE),    32'd0);
      check("rst_waddr", 32'(bus.PROG_WADDR), 32'd0);
      check("rst_wdata", 32'(bus.PROG_WDATA), 32'd0);
      check_flags("rst", 1'b0, 1'b0, 1'b0);
      RST_N = 1'b1;
      idle(2);

      // ---- table-driven frames ----
      for (int v = 0; v < 8; v++) begin
         wq.delete();
         bq.delete();
         for (int i = 0; i < vt[v].n; i++) bq.push_back(vt[v].b[i]);
         send(bq, 0);
         idle(3);
         check_flags($sformatf("vec%0d", v), vt[v].done, vt[v].err, vt[v].hold);
         check($sformatf("vec%0d_nwe", v), 32'(wq.size()), 32'(vt[v].nwe));
         if (vt[v].nwe > 0 && wq.size() > 0) begin
            check($sformatf("vec%0d_last_addr", v), 32'(wq[$].a), 32'(vt[v].last_a));
            check($sformatf("vec%0d_last_data", v), 32'(wq[$].d), 32'(vt[v].last_d));
         end
      end

      // ---- randomized frames against a frame-level reference model ----
      for (int f = 0; f < 25; f++) begin
         int          mode, cnt;
         logic [7:0]  sum, w2, w1, w0, junk;
         logic        good;
         wq.delete();
         bq.delete();
         exp_wq.delete();
         if ($urandom_range(3, 0) == 0) begin
            junk = 8'($urandom_range(255, 0));
            if (junk == 8'hA5) junk = 8'h5A;
            bq.push_back(junk);
         end
         mode = $urandom_range(9, 0);
         if (mode == 0)      cnt = 0;
         else if (mode == 1) cnt = $urandom_range(65535, 1025);
         else                cnt = $urandom_range(6, 1);
         bq.push_back(8'hA5);
         bq.push_back(8'(cnt >> 8));
         bq.push_back(8'(cnt));
         good = 1'b0;
         if (cnt >= 1 && cnt <= 1024) begin
            sum = 8'h00;
            for (int k = 0; k < cnt; k++) begin
               w2 = 8'($urandom_range(255, 0));
               w1 = 8'($urandom_range(255, 0));
               w0 = 8'($urandom_range(255, 0));
               bq.push_back(w2);
               bq.push_back(w1);
               bq.push_back(w0);
               sum = 8'((int'(sum) + int'(w2) + int'(w1) + int'(w0)) % 256);
               exp_wq.push_back('{AW'(k), {w2[1:0], w1, w0}});
            end
            good = ($urandom_range(9, 0) > 2);
            bq.push_back(good ? sum : sum ^ 8'($urandom_range(255, 1)));
         end
         send(bq, 3);
         idle(3);
         check_flags($sformatf("rnd%0d", f), good, !good, !good);
         check($sformatf("rnd%0d_nwe", f), 32'(wq.size()), 32'(exp_wq.size()));
         for (int k = 0; k < exp_wq.size() && k < wq.size(); k++) begin
            check($sformatf("rnd%0d_addr%0d", f, k), 32'(wq[k].a), 32'(exp_wq[k].a));
            check($sformatf("rnd%0d_data%0d", f, k), 32'(wq[k].d), 32'(exp_wq[k].d));
         end
      end

      // ---- timeout after two bytes of the first word ----
      RST_N = 1'b0;
      idle(1);
      RST_N = 1'b1;
      wq.delete();
      bq = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h23};
      send(bq, 0);
      begin
         int hit = -1;
         for (int i = 1; i <= 130 && hit < 0; i++) begin
            @(negedge CLK);
            if (LOAD_ERR === 1'b1) hit = i;
         end
         check("timeout_cycles", 32'(hit), 32'(TMO));
      end
      check("timeout_hold", 32'(MCU_HOLD), 32'd1);
      check("timeout_nwe",  32'(wq.size()), 32'd0);

      // ---- 1024-word frame, byte every cycle ----
      wq.delete();
      bq.delete();
      exp_wq.delete();
      begin
         logic [7:0] sum, w2, w1, w0;
         sum = 8'h00;
         bq.push_back(8'hA5);
         bq.push_back(8'h04);
         bq.push_back(8'h00);
         for (int k = 0; k < 1024; k++) begin
            w2 = 8'($urandom_range(255, 0));
            w1 = 8'($urandom_range(255, 0));
            w0 = 8'($urandom_range(255, 0));
            bq.push_back(w2);
            bq.push_back(w1);
            bq.push_back(w0);
            sum = 8'((int'(sum) + int'(w2) + int'(w1) + int'(w0)) % 256);
            exp_wq.push_back('{AW'(k), {w2[1:0], w1, w0}});
         end
         bq.push_back(sum);
      end
      send(bq, 0);
      idle(3);
      check_flags("long", 1'b1, 1'b0, 1'b0);
      check("long_nwe",        32'(wq.size()), 32'd1024);
      check("long_waddr_wrap", 32'(bus.PROG_WADDR), 32'd0);
      check("long_we_low",     32'(bus.PROG_WE), 32'd0);
      for (int k = 0; k < exp_wq.size() && k < wq.size(); k++) begin
         check($sformatf("long_addr%0d", k), 32'(wq[k].a), 32'(exp_wq[k].a));
         check($sformatf("long_data%0d", k), 32'(wq[k].d), 32'(exp_wq[k].d));
      end

      // ---- reset in the middle of a frame ----
      wq.delete();
      bq = '{8'hA5, 8'h00, 8'h08};
      for (int k = 0; k < 5; k++) begin
         bq.push_back(8'h01);
         bq.push_back(8'(k));
         bq.push_back(8'h10);
      end
      bq.push_back(8'h02);
      send(bq, 0);
      check("mid_hold_before", 32'(MCU_HOLD), 32'd1);
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      check("mid_we",    32'(bus.PROG_WE),    32'd0);
      check("mid_waddr", 32'(bus.PROG_WADDR), 32'd0);
      check("mid_wdata", 32'(bus.PROG_WDATA), 32'd0);
      check_flags("mid", 1'b0, 1'b0, 1'b0);
      check("mid_nwe", 32'(wq.size()), 32'd5);
      bq = '{8'h12, 8'h34};
      send(bq, 0);
      idle(2);
      check_flags("mid_ignored", 1'b0, 1'b0, 1'b0);
      check("mid_ignored_nwe", 32'(wq.size()), 32'd5);
      bq = '{8'hA5};
      send(bq, 0);
      check("mid_restart_hold", 32'(MCU_HOLD), 32'd1);
      bq = '{8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hEF};
      send(bq, 0);
      idle(3);
      check_flags("mid_reload", 1'b1, 1'b0, 1'b0);
      check("mid_reload_nwe", 32'(wq.size()), 32'd6);
      if (wq.size() > 0) begin
         check("mid_reload_addr", 32'(wq[$].a), 32'd0);
         check("mid_reload_data", 32'(wq[$].d), 32'h1A5A5);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the 1024x18 program memory. It receives a framed program image as a byte stream from the UART receiver (one-cycle RX_VALID strobes).
- It assembles 18-bit instruction words and writes them sequentially into the program RAM write port.
- It holds the MCU in reset for the whole load, then releases it.
- It sits between the UART RX block and the dual-port program memory that the MCU fetch path reads.

Parameters:
- ADDR_W, 10, program memory address width (depth 2^ADDR_W = 1024 words).
- TIMEOUT_CYCLES, 1000000, maximum CLK cycles allowed between consecutive bytes inside a frame (10 ms at 100 MHz).
- START_BYTE, 8'hA5, frame start marker.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST_N  input  1  synchronous active-low reset.
- RX_DATA  input  8  received byte, valid only when RX_VALID=1.
- RX_VALID  input  1  one-cycle strobe, one byte per strobe.
- PROG_WE  output  1  program RAM write enable, one-cycle pulse per word.
- PROG_WADDR  output  ADDR_W  program RAM write address.
- PROG_WDATA  output  18  program RAM write data.
- MCU_HOLD  output  1  1 = hold MCU in reset.
- LOAD_DONE  output  1  sticky: last frame loaded and checksum matched.
- LOAD_ERR  output  1  sticky: last frame failed (bad count, checksum, or timeout).

Behaviour:
- Reset (RST_N=0 at posedge) gives:
  - state=IDLE; PROG_WE=0; PROG_WADDR=0; PROG_WDATA=0; MCU_HOLD=0; LOAD_DONE=0; LOAD_ERR=0.
  - Word counter, checksum and timeout counter = 0.
  - Reset mid-frame aborts the frame immediately. Words already written stay in RAM.
- Frame format: START_BYTE, COUNT_HI, COUNT_LO, then COUNT words of 3 bytes each, then CHK.
  - Word byte order: B2 gives word[17:16] from bits[1:0] (bits[7:2] ignored), B1 gives word[15:8], B0 gives word[7:0].
  - CHK must equal the 8-bit sum mod 256 of all 3*COUNT word bytes, full 8 bits of each byte. Header bytes are excluded.
- State machine (transitions on accepted bytes, i.e. RX_VALID=1):
  - IDLE / DONE / ERR: byte==START_BYTE → CNT_HI. Same cycle: MCU_HOLD←1, LOAD_DONE←0, LOAD_ERR←0, PROG_WADDR←0, checksum←0. Any other byte is ignored.
  - CNT_HI → CNT_LO: latch count[15:8].
  - CNT_LO: latch count[7:0].
    - If the 16-bit count is 0 or >2^ADDR_W → ERR.
    - Otherwise → B2.
  - B2 → B1 → B0: latch bytes and add each to the checksum.
  - B0:
    - Next cycle PROG_WE=1 with PROG_WDATA = the assembled word and PROG_WADDR = the current address.
    - The cycle after the WE pulse, PROG_WADDR increments by 1.
    - If words written == count → CHK, else → B2.
    - The WE pulse is registered, so a byte arriving in the WE cycle is accepted normally; no byte is lost.
  - CHK:
    - byte==checksum → DONE: LOAD_DONE←1, MCU_HOLD←0.
    - Mismatch → ERR: LOAD_ERR←1, MCU_HOLD stays 1.
- START_BYTE inside a frame is data, not a restart.
- Timeout:
  - In CNT_HI..CHK, the counter increments each cycle without RX_VALID and clears on RX_VALID.
  - Reaching TIMEOUT_CYCLES → ERR, LOAD_ERR=1, MCU_HOLD stays 1.
  - The counter is held at 0 in IDLE/DONE/ERR.
- Address never wraps within a frame, because count ≤ 2^ADDR_W.
  - After a 1024-word frame, PROG_WADDR wraps to 0; this is harmless because WE=0.
- PROG_WE is never asserted outside the cycle after B0 acceptance.
- MCU_HOLD is 1 from START acceptance until DONE. ERR keeps the MCU held until a successful reload.

Test Plan:
- Reset, then bytes A5,00,02,01,23,45,02,AB,CD,E3 → WE pulses write 18'h12345 @0 and 18'h2ABCD @1. LOAD_DONE=1, MCU_HOLD=0, LOAD_ERR=0.
- Same frame with CHK=E4 → both words written, LOAD_ERR=1, LOAD_DONE=0, MCU_HOLD=1. Then resend the correct frame → LOAD_DONE=1, LOAD_ERR=0.
- Frames with count 0 (A5,00,00) and count 1025 (A5,04,01) → ERR immediately, no WE pulse, MCU_HOLD=1.
- Frame A5,00,01,01,23 then silence for TIMEOUT_CYCLES (bench overrides to 100) → LOAD_ERR=1 exactly 100 cycles after the last strobe, no WE.
- Back-to-back RX_VALID every cycle through a 1024-word frame → 1024 WE pulses at addresses 0..1023, no dropped bytes, LOAD_DONE=1.
- RST_N=0 during B1 of word 5 → all outputs reset next posedge, MCU_HOLD=0. Then bytes 12,34 are ignored until A5.
